multicycle_control: RTL and testbench

- Main control FSM of the multicycle datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback steps.
- Drives every datapath mux select (including the 2-to-1 source muxes) and all write enables.
- Upstream of the select muxes and register/memory enables: it sits between the instruction register opcode field and the datapath control inputs.

---
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every mux select and write enable.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t state_q;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Reset wins over every transition, so an interrupted instruction leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  state_q <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if ((opcode == OP_LW) || (opcode == OP_SW)) state_q <= S_MEMADR;
          else if (opcode == OP_RTYPE)                state_q <= S_EXEC;
          else if (opcode == OP_BEQ)                  state_q <= S_BRANCH;
          else if (opcode == OP_J)                    state_q <= S_JUMP;
          else if (opcode == OP_ADDI)                 state_q <= S_ADDIEX;
          else                                        state_q <= S_FETCH;
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_q <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  state_q <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   state_q <= S_ALUWB;
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Moore decode of the state register; only FETCH enables and illegal_op see inputs.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~is_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls and
// a mid-instruction reset, comparing state and the full control word every cycle.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: pcw pwc iord mrd mwr irw | m2r rdst rw asa | asb | aop | pcs | ill
  logic [16:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_source, illegal_op};

  localparam logic [16:0] W_IDLE   = 17'b000000_0000_00_00_00_0;
  localparam logic [16:0] W_FETCH  = 17'b100101_0000_01_00_00_0;
  localparam logic [16:0] W_FSTALL = 17'b000100_0000_01_00_00_0;
  localparam logic [16:0] W_DEC    = 17'b000000_0000_11_00_00_0;
  localparam logic [16:0] W_DECILL = 17'b000000_0000_11_00_00_1;
  localparam logic [16:0] W_MEMADR = 17'b000000_0001_10_00_00_0;
  localparam logic [16:0] W_MEMRD  = 17'b001100_0000_00_00_00_0;
  localparam logic [16:0] W_MEMWB  = 17'b000000_1010_00_00_00_0;
  localparam logic [16:0] W_MEMWR  = 17'b001010_0000_00_00_00_0;
  localparam logic [16:0] W_EXEC   = 17'b000000_0001_00_10_00_0;
  localparam logic [16:0] W_ALUWB  = 17'b000000_0110_00_00_00_0;
  localparam logic [16:0] W_BRANCH = 17'b010000_0001_00_01_01_0;
  localparam logic [16:0] W_ADDIWB = 17'b000000_0010_00_00_00_0;
  localparam logic [16:0] W_JUMP   = 17'b100000_0000_00_00_10_0;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_outs);
    chk({tag, ".state"}, {13'd0, state}, {13'd0, exp_state});
    chk({tag, ".ctrl"}, outs, exp_outs);
  endtask

  task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_outs);
    @(posedge clk);
    #1;
    look(tag, exp_state, exp_outs);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    look("reset", 4'd0, W_IDLE);
    rst_n  = 1'b1;
    opcode = 6'b100011;
    step("lw.fetch", 4'd1, W_FETCH);
    step("lw.dec", 4'd2, W_DEC);
    step("lw.adr", 4'd3, W_MEMADR);
    step("lw.rd", 4'd4, W_MEMRD);
    step("lw.wb", 4'd5, W_MEMWB);
    step("sw.fetch", 4'd1, W_FETCH);
    opcode = 6'b101011;
    step("sw.dec", 4'd2, W_DEC);
    step("sw.adr", 4'd3, W_MEMADR);
    mem_ready = 1'b0;
    step("sw.wr1", 4'd6, W_MEMWR);
    step("sw.wr2", 4'd6, W_MEMWR);
    step("sw.wr3", 4'd6, W_MEMWR);
    step("sw.wr4", 4'd6, W_MEMWR);
    mem_ready = 1'b1;
    step("r.fetch", 4'd1, W_FETCH);
    opcode = 6'b000000;
    step("r.dec", 4'd2, W_DEC);
    step("r.exec", 4'd7, W_EXEC);
    step("r.wb", 4'd8, W_ALUWB);
    step("beq.fetch", 4'd1, W_FETCH);
    opcode = 6'b000100;
    step("beq.dec", 4'd2, W_DEC);
    step("beq.br", 4'd9, W_BRANCH);
    step("j.fetch", 4'd1, W_FETCH);
    opcode = 6'b000010;
    step("j.dec", 4'd2, W_DEC);
    step("j.jump", 4'd12, W_JUMP);
    step("addi.fetch", 4'd1, W_FETCH);
    opcode = 6'b001000;
    step("addi.dec", 4'd2, W_DEC);
    step("addi.ex", 4'd10, W_MEMADR);
    step("addi.wb", 4'd11, W_ADDIWB);
    step("ill.fetch", 4'd1, W_FETCH);
    opcode = 6'b111111;
    step("ill.dec", 4'd2, W_DECILL);
    mem_ready = 1'b0;
    step("stall.f1", 4'd1, W_FSTALL);
    step("stall.f2", 4'd1, W_FSTALL);
    mem_ready = 1'b1;
    #1;
    look("stall.go", 4'd1, W_FETCH);
    opcode = 6'b100011;
    step("rst.dec", 4'd2, W_DEC);
    step("rst.adr", 4'd3, W_MEMADR);
    step("rst.rd", 4'd4, W_MEMRD);
    rst_n = 1'b0;
    step("rst.idle", 4'd0, W_IDLE);
    rst_n = 1'b1;
    step("rst.fetch", 4'd1, W_FETCH);
    step("rst.dec2", 4'd2, W_DEC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
